// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and drives IF/ID enable/clear.
// Optional feature macro FETCH_PERF_EN adds fetched-instruction and stall-cycle counters.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_valid,
    output logic            ifid_en,
`ifdef FETCH_PERF_EN
    output logic            ifid_clr,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall_cycles
`else
    output logic            ifid_clr
`endif
);

    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic [XLEN-1:0] target_s;
    logic            fetch_done_s;

    assign target_s = {redirect_pc[XLEN-1:2], 2'b00};

    // Next-state logic: redirect outranks ack/stall in every state.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        drop_addr_d  = drop_addr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = target_s;
                    if (imem_ack) begin
                        state_d = ST_REQ;
                    end else begin
                        // The in-flight request still has to complete before refetching.
                        drop_addr_d = pc_q;
                        state_d     = ST_DROP;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        hold_instr_d = imem_rdata;
                        state_d      = ST_HOLD;
                    end else begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = target_s;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    pc_d    = target_s;
                    state_d = ST_DROP;
                end else if (imem_ack) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory handshake and IF/ID-facing outputs.
    always_comb begin
        imem_req     = (state_q == ST_REQ) || (state_q == ST_DROP);
        imem_addr    = (state_q == ST_DROP) ? drop_addr_q : pc_q;
        fetch_done_s = ((state_q == ST_REQ) && imem_ack) || (state_q == ST_HOLD);
        out_pc       = pc_q;
        case (state_q)
            ST_REQ:  out_instr = imem_rdata;
            ST_HOLD: out_instr = hold_instr_q;
            default: out_instr = NOP_INSTR;
        endcase
        if (state_q == ST_IDLE) begin
            out_valid = 1'b0;
            ifid_en   = 1'b1;
            ifid_clr  = 1'b1;
        end else begin
            out_valid = fetch_done_s && !redirect_valid;
            ifid_en   = !stall || redirect_valid;
            ifid_clr  = redirect_valid || (!stall && !fetch_done_s);
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            drop_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            drop_addr_q  <= drop_addr_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (clr) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_q + {31'd0, (out_valid && ifid_en)};
            perf_stall_q   <= perf_stall_q + {31'd0, (stall && !redirect_valid)};
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect/ack traffic, checked by a
// program-order scoreboard (accepted instructions must follow pc+4 from the last redirect target).
module tb_fetch_unit;

    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_valid;
    logic        ifid_en;
    logic        ifid_clr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    logic [31:0] redir_q[$];

    always #5 clk = ~clk;

    // Instruction memory contents are a pure function of the address.
    assign imem_rdata = imem_addr ^ KEY;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .clr            (clr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_valid      (out_valid),
        .ifid_en        (ifid_en),
`ifdef FETCH_PERF_EN
        .ifid_clr          (ifid_clr),
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles)
`else
        .ifid_clr       (ifid_clr)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Scoreboard / reference model state
    logic [31:0] exp_pc = 32'd0;
    int          since = -1;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] m_fetched = 32'd0;
    logic [31:0] m_stall = 32'd0;
    logic        acc;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (clr) begin
`ifdef FETCH_PERF_EN
            if (since >= 0) begin
                check("perf_fetched", perf_fetched, m_fetched);
                check("perf_stall", perf_stall_cycles, m_stall);
            end
`endif
            since     = 0;
            exp_pc    = RESET_PC;
            prev_pend = 1'b0;
            m_fetched = 32'd0;
            m_stall   = 32'd0;
        end else if (since >= 0) begin
            since++;
`ifdef FETCH_PERF_EN
            check("perf_fetched", perf_fetched, m_fetched);
            check("perf_stall", perf_stall_cycles, m_stall);
`endif
            acc = out_valid && ifid_en;
            if (since == 1) begin
                check1("idle_en", ifid_en, 1'b1);
                check1("idle_clr", ifid_clr, 1'b1);
                check1("idle_valid", out_valid, 1'b0);
                check1("idle_req", imem_req, 1'b0);
                check("idle_addr", imem_addr, RESET_PC);
            end else begin
                check1("ifid_en", ifid_en, !stall || redirect_valid);
                check1("ifid_clr", ifid_clr, redirect_valid || (!stall && !out_valid));
                if (redirect_valid) check1("redir_kills_valid", out_valid, 1'b0);
                if (out_valid && !imem_ack) check1("hold_no_req", imem_req, 1'b0);
            end
            if (prev_pend) begin
                check1("req_kept", imem_req, 1'b1);
                check("addr_stable", imem_addr, prev_addr);
            end
            if (acc) begin
                check("stream_pc", out_pc, exp_pc);
                check("stream_instr", out_instr, exp_pc ^ KEY);
                exp_pc = exp_pc + 32'd4;
                n_acc++;
            end
            if (redirect_valid && since > 1) begin
                if (redir_q.size() == 0) begin
                    check1("redir_queue_nonempty", 1'b0, 1'b1);
                end else begin
                    exp_pc = redir_q.pop_front();
                end
            end
            m_fetched = m_fetched + (acc ? 32'd1 : 32'd0);
            m_stall   = m_stall + ((stall && !redirect_valid) ? 32'd1 : 32'd0);
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] t, input logic a);
        stall          = s;
        redirect_valid = r;
        redirect_pc    = t;
        imem_ack       = a;
        if (r) redir_q.push_back({t[31:2], 2'b00});
    endtask

    logic        rs, ra, rr;
    logic [31:0] rt;

    initial begin
        clr = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check1("c1_clr", ifid_clr, 1'b1);
        check1("c1_valid", out_valid, 1'b0);

        cyc(); @(negedge clk);
        check("c2_pc", out_pc, 32'd0);
        check("c2_instr", out_instr, 32'h0000_0000 ^ KEY);
        check1("c2_clr", ifid_clr, 1'b0);
        cyc(); @(negedge clk);
        check("c3_pc", out_pc, 32'd4);
        cyc(); drive(1'b1, 1'b0, 32'd0, 1'b1); @(negedge clk);
        check("stall_pc", out_pc, 32'd8);
        check1("stall_en", ifid_en, 1'b0);
        cyc(); @(negedge clk);
        check1("hold_req", imem_req, 1'b0);
        check("hold_instr", out_instr, 32'd8 ^ KEY);
        cyc(); @(negedge clk);
        check1("hold_en", ifid_en, 1'b0);
        cyc(); drive(1'b0, 1'b0, 32'd0, 1'b1); @(negedge clk);
        check("release_pc", out_pc, 32'd8);
        check1("release_valid", out_valid, 1'b1);
        cyc(); @(negedge clk);
        check("after_hold_pc", out_pc, 32'd12);
        cyc(); @(negedge clk);
        check("pre_redir_pc", out_pc, 32'd16);
        drive(1'b0, 1'b0, 32'd0, 1'b1);

        cyc(); drive(1'b0, 1'b1, 32'h0000_0103, 1'b1); @(negedge clk);
        check1("redir_clr", ifid_clr, 1'b1);
        check1("redir_valid", out_valid, 1'b0);
        cyc(); drive(1'b0, 1'b0, 32'd0, 1'b1); @(negedge clk);
        check("redir_addr", imem_addr, 32'h0000_0100);
        check1("redir_tgt_valid", out_valid, 1'b1);

        cyc(); drive(1'b0, 1'b1, 32'h0000_0014, 1'b1); @(negedge clk);
        cyc(); drive(1'b0, 1'b1, 32'h0000_0200, 1'b0); @(negedge clk);
        check("drop_entry_addr", imem_addr, 32'h0000_0014);
        cyc(); drive(1'b0, 1'b0, 32'd0, 1'b0); @(negedge clk);
        check("drop_addr1", imem_addr, 32'h0000_0014);
        check1("drop_req", imem_req, 1'b1);
        cyc(); @(negedge clk);
        check("drop_addr2", imem_addr, 32'h0000_0014);
        cyc(); drive(1'b0, 1'b0, 32'd0, 1'b1); @(negedge clk);
        check1("drop_ack_valid", out_valid, 1'b0);
        cyc(); @(negedge clk);
        check("post_drop_addr", imem_addr, 32'h0000_0200);
        check1("post_drop_valid", out_valid, 1'b1);

        cyc(); drive(1'b1, 1'b1, 32'h0000_0300, 1'b1); @(negedge clk);
        check1("stall_redir_en", ifid_en, 1'b1);
        check1("stall_redir_clr", ifid_clr, 1'b1);
        cyc(); drive(1'b0, 1'b0, 32'd0, 1'b1); @(negedge clk);
        check("stall_redir_pc", out_pc, 32'h0000_0300);

        cyc(); drive(1'b0, 1'b1, 32'h0000_0400, 1'b0); @(negedge clk);
        cyc(); drive(1'b0, 1'b0, 32'd0, 1'b0); clr = 1'b1; @(negedge clk);
        cyc(); clr = 1'b0; @(negedge clk);
        check1("clr_drop_req", imem_req, 1'b0);
        check("clr_drop_pc", out_pc, RESET_PC);
        cyc(); drive(1'b0, 1'b0, 32'd0, 1'b1); @(negedge clk);
        check("clr_restart_pc", out_pc, RESET_PC);

        cyc(); drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1); @(negedge clk);
        cyc(); drive(1'b0, 1'b0, 32'd0, 1'b1); @(negedge clk);
        check("wrap_top_pc", out_pc, 32'hFFFF_FFFC);
        cyc(); @(negedge clk);
        check("wrap_zero_pc", out_pc, 32'h0000_0000);

        // 10 accepted fetches then 3 stall cycles after a fresh reset
        cyc(); clr = 1'b1; @(negedge clk);
        cyc(); clr = 1'b0; @(negedge clk);
        repeat (10) begin cyc(); @(negedge clk); end
        cyc(); drive(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (2) begin cyc(); end
        cyc(); drive(1'b0, 1'b0, 32'd0, 1'b1); @(negedge clk);
`ifdef FETCH_PERF_EN
        check("perf10_fetched", perf_fetched, 32'd10);
        check("perf3_stall", perf_stall_cycles, 32'd3);
`endif
        check("after_perf_pc", out_pc, 32'd40);

        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (clr) begin
                clr = 1'b0;
                drive(1'($urandom_range(0, 3) == 0), 1'b0, 32'd0, 1'b1);
            end else if ($urandom_range(0, 299) == 0) begin
                clr = 1'b1;
                drive(1'b0, 1'b0, 32'd0, 1'b1);
            end else begin
                rs = ($urandom_range(0, 3) == 0);
                ra = ($urandom_range(0, 9) < 7);
                rr = ($urandom_range(0, 9) == 0);
                rt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
                drive(rs, rr, rt, ra);
            end
        end
        cyc();
        clr = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check1("liveness", n_acc > 500, 1'b1);
        check("redir_queue_drained", 32'(redir_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
